// File: rtl/ethtx_arb_pkg.sv
// Shared types and constants for the Ethernet transmit arbiter.
// The byte counter helper saturates so the oversize check can never wrap.
package ethtx_arb_pkg;

    localparam int LENW          = 11;
    localparam int DEF_MINLEN    = 60;
    localparam int DEF_MAXLEN    = 1514;
    localparam int DEF_IFG       = 12;
    localparam int DEF_START_TMO = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        XFER  = 3'd2,
        PAD   = 3'd3,
        DRAIN = 3'd4,
        GAP   = 3'd5
    } state_t;

    function automatic logic [LENW-1:0] sat_inc(input logic [LENW-1:0] v,
                                                 input logic [LENW-1:0] lim);
        if (v >= lim) begin
            return lim;
        end else begin
            return v + 11'd1;
        end
    endfunction

endpackage

// File: rtl/ethtx_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module ethtx_arb_rr_pick #(
    parameter int NREQ = 2,
    parameter int IDXW = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] pick,
    output logic [IDXW-1:0] idx,
    output logic            valid
);

    logic [IDXW-1:0] cand_s;

    // Scan requesters starting at the pointer; the first hit wins.
    always_comb begin
        pick   = '0;
        idx    = '0;
        valid  = 1'b0;
        cand_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = IDXW'((int'(ptr) + k) % NREQ);
            if (!valid && req[cand_s]) begin
                valid        = 1'b1;
                pick[cand_s] = 1'b1;
                idx          = cand_s;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/ethtx_arb.sv
// Transmit arbiter: round-robin grant of one frame at a time onto the shared
// byte stream, with runt padding, oversize truncation and inter-frame gap.
module ethtx_arb
    import ethtx_arb_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int MINLEN    = DEF_MINLEN,
    parameter int MAXLEN    = DEF_MAXLEN,
    parameter int IFG       = DEF_IFG,
    parameter int START_TMO = DEF_START_TMO
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] din,
    input  logic [NREQ-1:0]   dven,
    output logic [NREQ-1:0]   grant,
    output logic [7:0]        tx_data,
    output logic              tx_dven,
    output logic              tx_err,
    output logic              busy
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [LENW-1:0] MINLEN_C   = LENW'(MINLEN);
    localparam logic [LENW-1:0] MAXLEN_C   = LENW'(MAXLEN);
    localparam logic [LENW-1:0] IFG_LAST_C = LENW'(IFG - 1);
    localparam logic [LENW-1:0] TMO_LAST_C = LENW'(START_TMO - 1);

    logic [1:0]      rst_sync_r;
    logic            rst_n_s;
    state_t          state_r;
    logic [IDXW-1:0] ptr_r;
    logic [IDXW-1:0] gidx_r;
    logic [LENW-1:0] cnt_r;
    logic [LENW-1:0] aux_cnt_r;
    logic [NREQ-1:0] pick_s;
    logic [IDXW-1:0] pick_idx_s;
    logic            pick_valid_s;
    logic [IDXW-1:0] next_ptr_s;
    logic            dven_s;
    logic [7:0]      din_s;

    // Reset synchronizer: asserts asynchronously, releases two clocks later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];
    assign dven_s  = dven[gidx_r];
    assign din_s   = din[{gidx_r, 3'b000} +: 8];

    ethtx_arb_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_r),
        .pick  (pick_s),
        .idx   (pick_idx_s),
        .valid (pick_valid_s)
    );

    // Pointer value taken on grant release: one past the granted source.
    always_comb begin
        next_ptr_s = '0;
        if (gidx_r == IDXW'(NREQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = gidx_r + IDXW'(1);
        end
    end

    // Arbitration FSM with registered grant, datapath and status outputs.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r   <= IDLE;
            ptr_r     <= '0;
            gidx_r    <= '0;
            cnt_r     <= '0;
            aux_cnt_r <= '0;
            grant     <= '0;
            tx_data   <= 8'h00;
            tx_dven   <= 1'b0;
            tx_err    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            tx_err  <= 1'b0;
            tx_dven <= 1'b0;
            tx_data <= 8'h00;
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        grant     <= pick_s;
                        gidx_r    <= pick_idx_s;
                        cnt_r     <= '0;
                        aux_cnt_r <= '0;
                        busy      <= 1'b1;
                        state_r   <= WAIT;
                    end else begin
                        grant <= '0;
                    end
                end
                WAIT: begin
                    if (dven_s) begin
                        tx_data <= din_s;
                        tx_dven <= 1'b1;
                        cnt_r   <= 11'd1;
                        state_r <= XFER;
                    end else if (aux_cnt_r == TMO_LAST_C) begin
                        grant     <= '0;
                        tx_err    <= 1'b1;
                        ptr_r     <= next_ptr_s;
                        aux_cnt_r <= '0;
                        state_r   <= GAP;
                    end else begin
                        aux_cnt_r <= aux_cnt_r + 11'd1;
                    end
                end
                XFER: begin
                    if (dven_s) begin
                        if (cnt_r >= MAXLEN_C) begin
                            tx_err  <= 1'b1;
                            state_r <= DRAIN;
                        end else begin
                            tx_data <= din_s;
                            tx_dven <= 1'b1;
                            cnt_r   <= sat_inc(cnt_r, MAXLEN_C);
                        end
                    end else begin
                        grant     <= '0;
                        ptr_r     <= next_ptr_s;
                        aux_cnt_r <= '0;
                        if (cnt_r >= MINLEN_C) begin
                            state_r <= GAP;
                        end else begin
                            // first pad byte follows the last source byte with no bubble
                            tx_dven <= 1'b1;
                            cnt_r   <= sat_inc(cnt_r, MAXLEN_C);
                            state_r <= PAD;
                        end
                    end
                end
                PAD: begin
                    if (cnt_r >= MINLEN_C) begin
                        aux_cnt_r <= '0;
                        state_r   <= GAP;
                    end else begin
                        tx_dven <= 1'b1;
                        cnt_r   <= sat_inc(cnt_r, MAXLEN_C);
                    end
                end
                DRAIN: begin
                    if (!dven_s) begin
                        grant     <= '0;
                        ptr_r     <= next_ptr_s;
                        aux_cnt_r <= '0;
                        state_r   <= GAP;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                GAP: begin
                    if (aux_cnt_r == IFG_LAST_C) begin
                        aux_cnt_r <= '0;
                        // the last gap cycle also makes the idle decision, so the
                        // next grant lands IFG+1 cycles after the last tx byte
                        if (pick_valid_s) begin
                            grant   <= pick_s;
                            gidx_r  <= pick_idx_s;
                            cnt_r   <= '0;
                            state_r <= WAIT;
                        end else begin
                            busy    <= 1'b0;
                            state_r <= IDLE;
                        end
                    end else begin
                        aux_cnt_r <= aux_cnt_r + 11'd1;
                    end
                end
                default: begin
                    grant   <= '0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
